// File: rtl/mem_responder_pkg.sv
// Shared encodings for the cache/memory byte bus and the I/O window register map.
package mem_responder_pkg;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [2:0] IO_TX_DATA = 3'd0;
   localparam logic [2:0] IO_STATUS  = 3'd4;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_OVF   = 2;

   function automatic logic [7:0] pack_status(input logic ovf, input logic empty, input logic full);
      logic [7:0] s;
      s           = '0;
      s[ST_OVF]   = ovf;
      s[ST_EMPTY] = empty;
      s[ST_FULL]  = full;
      return s;
   endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push/pop are gated internally so it can never over/underflow.
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int AWIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int DEPTH = 1 << AWIDTH;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AWIDTH:0]  wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]  rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]) &&
                    (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]);
   assign data_o  = mem_q[rd_ptr_q[AWIDTH-1:0]];

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AWIDTH-1:0]] <= data_i;
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte RAM with one-cycle registered reads plus an I/O window holding a TX FIFO.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int IO_BIT     = 17,
   parameter int FIFO_WIDTH = 3
) (
   input  logic        clkIn,
   input  logic        resetIn,
   input  logic        readyIn,
   input  logic        readWriteIn,
   input  logic [31:0] addrIn,
   input  logic [7:0]  dataIn,
   output logic [7:0]  dataOut,
   output logic        txValid,
   output logic [7:0]  txData,
   input  logic        txReady,
   output logic        txFull
);

   logic [7:0]            ram_q [2**ADDR_WIDTH];
   logic [7:0]            dataOut_q, dataOut_d;
   logic                  ovf_q, ovf_d;

   logic                  is_io, is_rd, is_wr;
   logic [2:0]            io_off;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic                  tx_push_req, tx_pop, ovf_set, ovf_clr;
   logic                  fifo_full, fifo_empty;
   logic [7:0]            fifo_head;
   logic [7:0]            io_rdata;

   // Address bits outside the RAM decode and IO_BIT are don't-care.
   logic                  unused_addr;
   assign unused_addr = ^addrIn;

   assign is_io    = addrIn[IO_BIT];
   assign io_off   = addrIn[2:0];
   assign ram_addr = addrIn[ADDR_WIDTH-1:0];
   assign is_rd    = readyIn && (readWriteIn == RW_READ);
   assign is_wr    = readyIn && (readWriteIn == RW_WRITE);

   assign ram_we      = is_wr && !is_io;
   assign tx_push_req = is_wr && is_io && (io_off == IO_TX_DATA);
   assign ovf_clr     = is_wr && is_io && (io_off == IO_STATUS);
   // Draining keeps running while readyIn is low.
   assign tx_pop      = !fifo_empty && txReady;
   assign ovf_set     = tx_push_req && fifo_full && !tx_pop;

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_comb begin
      io_rdata = 8'h00;
      if (io_off == IO_STATUS) io_rdata = pack_status(ovf_q, fifo_empty, fifo_full);
   end

   always_comb begin
      dataOut_d = dataOut_q;
      if (is_rd) dataOut_d = is_io ? io_rdata : ram_q[ram_addr];
   end

   always_ff @(posedge clkIn or posedge resetIn) begin
      if (resetIn) begin
         dataOut_q <= 8'h00;
         ovf_q     <= 1'b0;
      end else begin
         dataOut_q <= dataOut_d;
         ovf_q     <= ovf_d;
      end
   end

   // Contents survive reset.
   always_ff @(posedge clkIn) begin
      if (ram_we) ram_q[ram_addr] <= dataIn;
   end

   sync_fifo #(
      .WIDTH  (8),
      .AWIDTH (FIFO_WIDTH)
   ) u_tx_fifo (
      .clk_i   (clkIn),
      .rst_i   (resetIn),
      .push_i  (tx_push_req),
      .pop_i   (tx_pop),
      .data_i  (dataIn),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign dataOut = dataOut_q;
   assign txValid = !fifo_empty;
   assign txData  = fifo_head;
   assign txFull  = fifo_full;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM timing, readyIn freeze, TX FIFO full/overflow, async reset.
module tb_mem_responder;

   logic        clkIn = 1'b0;
   logic        resetIn;
   logic        readyIn;
   logic        readWriteIn;
   logic [31:0] addrIn;
   logic [7:0]  dataIn;
   logic [7:0]  dataOut;
   logic        txValid;
   logic [7:0]  txData;
   logic        txReady;
   logic        txFull;

   int total = 0;
   int bad   = 0;

   mem_responder dut (
      .clkIn       (clkIn),
      .resetIn     (resetIn),
      .readyIn     (readyIn),
      .readWriteIn (readWriteIn),
      .addrIn      (addrIn),
      .dataIn      (dataIn),
      .dataOut     (dataOut),
      .txValid     (txValid),
      .txData      (txData),
      .txReady     (txReady),
      .txFull      (txFull)
   );

   always #5 clkIn = ~clkIn;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after a rising edge; outputs are sampled there too.
   task automatic cyc();
      @(posedge clkIn);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      readyIn = 1'b1; readWriteIn = 1'b0; addrIn = a; dataIn = d;
      cyc();
      readyIn = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      readyIn = 1'b1; readWriteIn = 1'b1; addrIn = a;
      cyc();
      readyIn = 1'b0;
   endtask

   initial begin
      resetIn = 1'b1; readyIn = 1'b0; readWriteIn = 1'b1;
      addrIn = '0; dataIn = '0; txReady = 1'b0;
      #12;
      chk("rst_dataOut", dataOut, 8'h00);
      chk("rst_txValid", txValid, 1'b0);
      chk("rst_txFull",  txFull,  1'b0);
      @(negedge clkIn); resetIn = 1'b0;

      // Write/read-after-write, neighbour untouched
      wr(32'h11, 8'h3C);
      wr(32'h10, 8'hA5);
      rd(32'h10);
      chk("raw_10", dataOut, 8'hA5);
      rd(32'h11);
      chk("neighbour_11", dataOut, 8'h3C);
      // Bits above the decode (other than IO_BIT) alias onto RAM
      rd(32'h8000_0010);
      chk("alias_hi", dataOut, 8'hA5);

      // Block fill: 16 back-to-back reads
      for (int i = 0; i < 16; i++) wr(32'h100 + i, 8'(i));
      readyIn = 1'b1; readWriteIn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         addrIn = 32'h100 + i;
         cyc();
         chk($sformatf("burst_%0d", i), dataOut, 8'(i));
      end
      readyIn = 1'b0;

      // readyIn freeze
      wr(32'h20, 8'h11);
      rd(32'h10);
      readWriteIn = 1'b0; addrIn = 32'h20; dataIn = 8'h99;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("frozen_hold_%0d", i), dataOut, 8'hA5);
      end
      rd(32'h20);
      chk("frozen_no_write", dataOut, 8'h11);
      wr(32'h20, 8'h99);
      rd(32'h20);
      chk("thaw_write", dataOut, 8'h99);

      // Fill TX FIFO, overflow on 9th push
      txReady = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(32'h20000, 8'h30 + 8'(i));
         if (i == 6) chk("txFull_after7", txFull, 1'b0);
         if (i == 7) chk("txFull_after8", txFull, 1'b1);
      end
      chk("head_30", txData, 8'h30);
      chk("txValid_full", txValid, 1'b1);
      rd(32'h20004);
      chk("status_ovf_full", dataOut, 8'h05);
      rd(32'h20000);
      chk("io_off0_read", dataOut, 8'h00);

      // Push and pop together while full
      txReady = 1'b1;
      wr(32'h20000, 8'h77);
      txReady = 1'b0;
      chk("pp_full", txFull, 1'b1);
      chk("pp_head", txData, 8'h31);
      rd(32'h20004);
      chk("pp_status", dataOut, 8'h05);

      // Drain with readyIn low
      begin
         logic [7:0] exp_q [8];
         for (int i = 0; i < 7; i++) exp_q[i] = 8'h31 + 8'(i);
         exp_q[7] = 8'h77;
         readyIn = 1'b0; txReady = 1'b1;
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), txData, exp_q[i]);
            cyc();
         end
         txReady = 1'b0;
      end
      chk("drained_valid", txValid, 1'b0);
      chk("drained_full", txFull, 1'b0);
      wr(32'h20004, 8'hFF);
      rd(32'h20004);
      chk("status_cleared", dataOut, 8'h02);

      // Async reset mid-stream with 3 queued and overflow set
      for (int i = 0; i < 9; i++) wr(32'h20000, 8'h40 + 8'(i));
      readyIn = 1'b0; txReady = 1'b1;
      repeat (5) cyc();
      txReady = 1'b0;
      chk("pre_rst_head", txData, 8'h45);
      rd(32'h20004);
      chk("pre_rst_status", dataOut, 8'h04);
      rd(32'h10);
      #2 resetIn = 1'b1;
      #1;
      chk("arst_txValid", txValid, 1'b0);
      chk("arst_dataOut", dataOut, 8'h00);
      chk("arst_txFull",  txFull,  1'b0);
      @(negedge clkIn); resetIn = 1'b0;
      rd(32'h20004);
      chk("post_rst_status", dataOut, 8'h02);
      rd(32'h10);
      chk("post_rst_ram10", dataOut, 8'hA5);
      rd(32'h105);
      chk("post_rst_ram105", dataOut, 8'h05);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the byte-wide cache/memory bus. It receives the cache controller's per-cycle address, read/write select and write byte, and returns read bytes with a fixed one-cycle latency.
- Backing store is a byte-addressed RAM.
- One address bit selects a small I/O window. That window holds a transmit FIFO with a valid/ready drain port and a status register.
- Sits between the cache controller and the off-chip/host link.

Parameters:
- ADDR_WIDTH, 17, byte-address bits decoded for RAM (RAM size 2^ADDR_WIDTH bytes).
- IO_BIT, 17, address bit that selects the I/O window when 1.
- FIFO_WIDTH, 3, log2 of TX FIFO depth (default 8 entries).

Ports:
- clkIn  input  1  system clock
- resetIn  input  1  asynchronous, active-high reset
- readyIn  input  1  global enable; 0 = freeze all state
- readWriteIn  input  1  1 = read, 0 = write (same encoding as cache readWriteOut)
- addrIn  input  32  byte address
- dataIn  input  8  write byte
- dataOut  output  8  read byte, registered
- txValid  output  1  TX FIFO head valid
- txData  output  8  TX FIFO head byte
- txReady  input  1  consumer accepts head
- txFull  output  1  TX FIFO full

Behaviour:
- Reset (async, resetIn=1): dataOut=0, FIFO empty, txValid=0, txFull=0, overflow flag=0.
  - RAM contents are not reset.
  - Reset mid-transfer aborts everything; the first request after release is served normally.
- Transaction accepted on a rising edge with readyIn=1. With readyIn=0, no RAM, FIFO or flag state changes and dataOut holds. The TX drain port still pops when txValid&&txReady.
- Address decode: addrIn[IO_BIT]=0 selects RAM at addrIn[ADDR_WIDTH-1:0]. Bits above ADDR_WIDTH, other than IO_BIT, are ignored.
- RAM read:
  - Address presented in cycle N; byte appears on dataOut after edge N+1 and holds until the next accepted read.
  - Back-to-back reads stream one byte per cycle. This is the pattern of a 16-byte block fill.
- RAM write: RAM[addr] <= dataIn at the accepting edge. dataOut is unchanged by writes.
- Read-after-write: a read of the same address in cycle N+1 returns the new byte. No bypass is needed, since the write lands at edge N.
- I/O window, offset = addrIn[2:0]:
  - Offset 0, write: push dataIn into the TX FIFO.
  - Offset 0, read: returns 0.
  - Offset 4, read: status {5'b0, overflow, empty, full}.
  - Offset 4, write: any value clears overflow.
  - Other offsets: reads return 0, writes are ignored.
  - I/O reads have the same one-cycle latency as RAM reads. Status reflects the value before the edge.
- TX FIFO:
  - Depth 2^FIFO_WIDTH.
  - Read and write pointers are FIFO_WIDTH+1 bits; wrap-around uses the extra bit.
  - empty = pointers equal; full = low bits equal and MSBs differ.
  - txValid = !empty; txData = mem[rdPtr] (combinational from the array).
  - Pop on txValid&&txReady.
  - Push while full and no pop in the same cycle: byte dropped, overflow <= 1 (sticky).
  - Push while full with a pop in the same cycle: push accepted and count unchanged.
  - Push and pop together when not full: both happen.
  - Overflow set and clear in the same cycle: set wins.
- txFull is registered-equivalent, derived from the pointers only (no combinational path from txReady).

Decomposition:
- Shared package holds:
  - RW_READ=1'b1 and RW_WRITE=1'b0.
  - IO offsets IO_TX_DATA=3'd0 and IO_STATUS=3'd4.
  - Status bit indices.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty, overflow-free interface). mem_responder owns the decode, RAM array, dataOut register and overflow flag.

Test Plan:
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> dataOut=0xA5 one cycle after the read address; 0x00011 untouched.
- Write bytes 0x00..0x0F to 0x100..0x10F, then 16 consecutive reads -> dataOut sequence 0x00..0x0F, each one cycle after its address, no bubbles.
- readyIn=0 for 3 cycles with a write to 0x20 asserted -> RAM[0x20] unchanged, dataOut held. Raise readyIn -> write takes effect.
- txReady=0, push 9 bytes to 0x20000 -> 8 queued; txFull=1 after the 8th. 9th dropped, and status read at 0x20004 returns 0x05 (overflow=1, full=1).
- Full FIFO, txReady=1 and push 0x77 in the same cycle -> head popped, 0x77 queued, txFull stays 1, overflow unchanged. Drain all -> last byte 0x77, txValid=0.
- Assert resetIn asynchronously mid-stream (FIFO 3 deep, overflow=1) -> txValid=0, dataOut=0 and status reads 0x02 immediately after release; previous RAM contents still readable.
